// File: rtl/decode_hazard_pipe_if.sv
// Fetch/decode boundary bundle: the fetch-side PC/instruction pair going in,
// and the EX register plus the stall/flush controls coming back to fetch.
interface decode_hazard_pipe_if;
    logic [31:0] pc_in;
    logic [31:0] instruction_in;
    logic        branch_taken;
    logic [31:0] pc_ex;
    logic [31:0] instr_ex;
    logic        valid_ex;
    logic        load_stall;
    logic        jal_flush;
    logic        jalr_flush;
    logic        branch_flush;

    modport master (
        output pc_in, instruction_in, branch_taken,
        input  pc_ex, instr_ex, valid_ex,
        input  load_stall, jal_flush, jalr_flush, branch_flush
    );

    modport slave (
        input  pc_in, instruction_in, branch_taken,
        output pc_ex, instr_ex, valid_ex,
        output load_stall, jal_flush, jalr_flush, branch_flush
    );
endinterface

// File: rtl/decode_hazard_pipe.sv
// Decode stage: latches the fetched PC/instruction into the EX register,
// detects load-use hazards and control transfers, and masks stale fetch words after a flush.
module decode_hazard_pipe #(
    parameter int          FLUSH_SHADOW = 2,
    parameter logic [31:0] BUBBLE       = 32'h0000_0000
) (
    input logic             clk,
    input logic             rst,
    decode_hazard_pipe_if.slave bus
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_NONE   = 7'b0000000;

    localparam logic [2:0] SHADOW_INIT = 3'(FLUSH_SHADOW);

    typedef enum logic [1:0] {
        RUN,
        STALL,
        SHADOW
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_ex_q, pc_ex_d;
    logic [31:0] instr_ex_q, instr_ex_d;
    logic        valid_ex_q, valid_ex_d;
    logic [2:0]  shadow_cnt_q, shadow_cnt_d;

    logic [6:0]  ex_opcode;
    logic [4:0]  ex_rd;
    logic [6:0]  in_opcode;
    logic [4:0]  in_rs1;
    logic [4:0]  in_rs2;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        ctrl_en;
    logic        jal_flush;
    logic        jalr_flush;
    logic        branch_flush;
    logic        flush_any;
    logic        load_stall;
    logic        take_bubble;

    always_comb begin
        ex_opcode = instr_ex_q[6:0];
        ex_rd     = instr_ex_q[11:7];
        in_opcode = bus.instruction_in[6:0];
        in_rs1    = bus.instruction_in[19:15];
        in_rs2    = bus.instruction_in[24:20];

        uses_rs1 = 1'b1;
        case (in_opcode)
            OP_LUI, OP_AUIPC, OP_JAL, OP_NONE: uses_rs1 = 1'b0;
            default:                           uses_rs1 = 1'b1;
        endcase
        uses_rs2 = (in_opcode == OP_R) || (in_opcode == OP_STORE) || (in_opcode == OP_BRANCH);

        // Controls only fire from a real instruction while running normally.
        ctrl_en      = valid_ex_q && (state_q == RUN);
        jal_flush    = ctrl_en && (ex_opcode == OP_JAL);
        jalr_flush   = ctrl_en && (ex_opcode == OP_JALR);
        branch_flush = ctrl_en && (ex_opcode == OP_BRANCH) && bus.branch_taken;
        flush_any    = jal_flush || jalr_flush || branch_flush;

        load_stall = ctrl_en && !flush_any && (ex_opcode == OP_LOAD) && (ex_rd != 5'd0) &&
                     ((uses_rs1 && (in_rs1 == ex_rd)) || (uses_rs2 && (in_rs2 == ex_rd)));
    end

    always_comb begin
        state_d      = state_q;
        shadow_cnt_d = shadow_cnt_q;
        take_bubble  = 1'b0;
        pc_ex_d      = bus.pc_in;
        instr_ex_d   = bus.instruction_in;
        valid_ex_d   = (bus.instruction_in != 32'd0);

        case (state_q)
            RUN: begin
                if (flush_any) begin
                    take_bubble = 1'b1;
                    if (FLUSH_SHADOW > 0) begin
                        shadow_cnt_d = SHADOW_INIT;
                        state_d      = SHADOW;
                    end
                end else if (load_stall) begin
                    take_bubble = 1'b1;
                    state_d     = STALL;
                end
            end
            STALL: begin
                state_d = RUN;
            end
            SHADOW: begin
                take_bubble  = 1'b1;
                shadow_cnt_d = shadow_cnt_q - 3'd1;
                if (shadow_cnt_q <= 3'd1) begin
                    shadow_cnt_d = 3'd0;
                    state_d      = RUN;
                end
            end
            default: begin
                take_bubble  = 1'b1;
                shadow_cnt_d = 3'd0;
                state_d      = RUN;
            end
        endcase

        if (take_bubble) begin
            pc_ex_d    = 32'd0;
            instr_ex_d = BUBBLE;
            valid_ex_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            shadow_cnt_q <= 3'd0;
            pc_ex_q      <= 32'd0;
            instr_ex_q   <= BUBBLE;
            valid_ex_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shadow_cnt_q <= shadow_cnt_d;
            pc_ex_q      <= pc_ex_d;
            instr_ex_q   <= instr_ex_d;
            valid_ex_q   <= valid_ex_d;
        end
    end

    assign bus.pc_ex        = pc_ex_q;
    assign bus.instr_ex     = instr_ex_q;
    assign bus.valid_ex     = valid_ex_q;
    assign bus.load_stall   = load_stall;
    assign bus.jal_flush    = jal_flush;
    assign bus.jalr_flush   = jalr_flush;
    assign bus.branch_flush = branch_flush;

endmodule

// File: tb/tb_decode_hazard_pipe.sv
// Directed and randomized bench for decode_hazard_pipe, checked every cycle
// against a cycle-level reference model of the decode rules.
module tb_decode_hazard_pipe;

    localparam int          FLUSH_SHADOW = 2;
    localparam logic [31:0] BUBBLE       = 32'h0000_0000;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_hazard_pipe_if bus ();

    decode_hazard_pipe #(
        .FLUSH_SHADOW(FLUSH_SHADOW),
        .BUBBLE      (BUBBLE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: EX contents plus how many upcoming fetch words are to be thrown away.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    bit          m_valid;
    bit          m_stall_cycle;
    int          m_discard;
    bit          m_known;
    logic [31:0] pc_gen;

    function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] r);
        logic [6:0] op;
        bit r1, r2;
        op = ins[6:0];
        r1 = !(op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b0000000});
        r2 = op inside {7'b0110011, 7'b0100011, 7'b1100011};
        return (r1 && ins[19:15] == r) || (r2 && ins[24:20] == r);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] ins, input bit bt, input bit r);
        bit run, e_jal, e_jalr, e_br, e_flush, e_stall;
        rst                = r;
        bus.pc_in          = pc;
        bus.instruction_in = ins;
        bus.branch_taken   = bt;
        #2;
        run     = !m_stall_cycle && (m_discard == 0);
        e_jal   = m_valid && run && (m_instr[6:0] == OP_JAL);
        e_jalr  = m_valid && run && (m_instr[6:0] == OP_JALR);
        e_br    = m_valid && run && (m_instr[6:0] == OP_BRANCH) && bt;
        e_flush = e_jal || e_jalr || e_br;
        e_stall = m_valid && run && !e_flush && (m_instr[6:0] == OP_LOAD) &&
                  (m_instr[11:7] != 5'd0) && reads_reg(ins, m_instr[11:7]);
        if (m_known) begin
            checkOutput("pc_ex", bus.pc_ex, m_pc);
            checkOutput("instr_ex", bus.instr_ex, m_instr);
            checkOutput("valid_ex", 32'(bus.valid_ex), 32'(m_valid));
            checkOutput("load_stall", 32'(bus.load_stall), 32'(e_stall));
            checkOutput("jal_flush", 32'(bus.jal_flush), 32'(e_jal));
            checkOutput("jalr_flush", 32'(bus.jalr_flush), 32'(e_jalr));
            checkOutput("branch_flush", 32'(bus.branch_flush), 32'(e_br));
        end
        if (r) begin
            m_pc = 32'd0; m_instr = BUBBLE; m_valid = 1'b0;
            m_stall_cycle = 1'b0; m_discard = 0; m_known = 1'b1;
        end else if (e_flush) begin
            m_pc = 32'd0; m_instr = BUBBLE; m_valid = 1'b0;
            m_discard = FLUSH_SHADOW;
        end else if (m_discard > 0) begin
            m_pc = 32'd0; m_instr = BUBBLE; m_valid = 1'b0;
            m_discard--;
        end else if (e_stall) begin
            m_pc = 32'd0; m_instr = BUBBLE; m_valid = 1'b0;
            m_stall_cycle = 1'b1;
        end else begin
            m_pc = pc; m_instr = ins; m_valid = (ins != 32'd0);
            m_stall_cycle = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input bit bt, input bit r);
        applyStimulus(pc_gen, ins, bt, r);
        pc_gen += 32'd4;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] ops [9];
        logic [31:0] w;
        ops = '{7'b0000011, 7'b1101111, 7'b1100111, 7'b1100011, 7'b0110011,
                7'b0100011, 7'b0110111, 7'b0010011, 7'b0000000};
        if ($urandom_range(0, 15) == 0) return 32'd0;
        w        = $urandom;
        w[6:0]   = ops[$urandom_range(0, 8)];
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    initial begin
        m_pc = 0; m_instr = BUBBLE; m_valid = 0; m_stall_cycle = 0;
        m_discard = 0; m_known = 0; pc_gen = 32'h100;
        rst = 1'b1; bus.pc_in = 0; bus.instruction_in = 0; bus.branch_taken = 0;
        @(posedge clk);
        #1;

        $display("[TB] reset");
        issue(32'h00228333, 0, 1);
        issue(32'h00228333, 0, 1);
        checkOutput("reset_instr", bus.instr_ex, 32'h0);
        checkOutput("reset_valid", 32'(bus.valid_ex), 32'd0);
        issue(32'h00228333, 0, 0);
        checkOutput("release_instr", bus.instr_ex, 32'h00228333);
        checkOutput("release_valid", 32'(bus.valid_ex), 32'd1);

        $display("[TB] load-use");
        issue(32'h0000A283, 0, 0);
        issue(32'h00228333, 0, 0);
        checkOutput("stall_bubble", 32'(bus.valid_ex), 32'd0);
        issue(32'h00228333, 0, 0);
        checkOutput("after_stall_instr", bus.instr_ex, 32'h00228333);

        $display("[TB] no hazard on x0");
        issue(32'h0000A003, 0, 0);
        issue(32'h00200333, 0, 0);
        checkOutput("nohaz_instr", bus.instr_ex, 32'h00200333);

        $display("[TB] jal with shadow");
        issue(32'h008000EF, 0, 0);
        issue(32'hFFFFFFFF, 0, 0);
        issue(32'hDEADBEEF, 0, 0);
        issue(32'hFFFFFFFF, 0, 0);
        checkOutput("shadow_bubble", 32'(bus.valid_ex), 32'd0);
        issue(32'h00100093, 0, 0);
        checkOutput("post_shadow_instr", bus.instr_ex, 32'h00100093);

        $display("[TB] branches and jalr");
        issue(32'h00000463, 0, 0);
        issue(32'h00000013, 0, 0);
        issue(32'h00000463, 0, 0);
        issue(32'h00000013, 1, 0);
        issue(32'hFFFFFFFF, 0, 0);
        issue(32'hFFFFFFFF, 0, 0);
        issue(32'h00500113, 0, 0);
        checkOutput("post_branch_instr", bus.instr_ex, 32'h00500113);
        issue(32'h000080E7, 0, 0);
        issue(32'h0000A083, 0, 0);
        issue(32'hFFFFFFFF, 0, 0);
        issue(32'hFFFFFFFF, 0, 0);

        $display("[TB] reset mid-shadow");
        issue(32'h008000EF, 0, 0);
        issue(32'hFFFFFFFF, 0, 0);
        issue(32'hFFFFFFFF, 0, 0);
        issue(32'hFFFFFFFF, 0, 1);
        checkOutput("midreset_valid", 32'(bus.valid_ex), 32'd0);
        issue(32'h00000013, 0, 0);
        checkOutput("midreset_next", bus.instr_ex, 32'h00000013);

        $display("[TB] random");
        for (int i = 0; i < 600; i++) begin
            issue(rand_instr(), 1'($urandom_range(0, 1)), $urandom_range(0, 49) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
